// File: rtl/assoc_branch_target_predictor.sv
// -----------------------------------------------------------------------------
// assoc_branch_target_predictor
//
// N-way set-associative branch target buffer for the IF stage. Each entry
// holds a valid bit, a tag, a branch target and a saturating direction counter.
// Each set also holds a round-robin replacement pointer.
//
// Lookups are combinational on the fetch PC. Resolved-branch updates from EX
// are applied at the clock edge. A two-state flush engine (IDLE/FLUSH) sweeps
// every set after reset or on request. It invalidates one set per cycle.
//
// Ports
//   clk, rst        clock; synchronous active-high reset (starts a sweep)
//   lookup_pc_i     fetch PC to look up
//   hit_o           lookup PC present in a valid entry (forced 0 while busy)
//   pred_taken_o    MSB of the hit entry's counter
//   target_o        stored target of the hit entry (0 on miss / busy)
//   upd_valid_i     resolved-branch update strobe
//   upd_pc_i        PC of the resolved branch
//   upd_taken_i     actual outcome
//   upd_target_i    actual target
//   flush_i         request a full invalidate
//   busy_o          flush sweep in progress (state == FLUSH)
//
// Update handshake: there is no ready. An update is consumed in the cycle
// upd_valid_i is high only when the engine is IDLE, flush_i is low and rst is
// low. In any other cycle the update is silently dropped. The caller can
// observe this through busy_o.
// -----------------------------------------------------------------------------
module assoc_branch_target_predictor #(
  parameter int ADDR_WIDTH  = 32,
  parameter int SETS        = 64,
  parameter int WAYS        = 2,
  parameter int CTR_WIDTH   = 2,
  parameter int OFFSET_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] lookup_pc_i,
  output logic                  hit_o,
  output logic                  pred_taken_o,
  output logic [ADDR_WIDTH-1:0] target_o,
  input  logic                  upd_valid_i,
  input  logic [ADDR_WIDTH-1:0] upd_pc_i,
  input  logic                  upd_taken_i,
  input  logic [ADDR_WIDTH-1:0] upd_target_i,
  input  logic                  flush_i,
  output logic                  busy_o
);

  localparam int INDEX_WIDTH = $clog2(SETS);
  localparam int TAG_WIDTH   = ADDR_WIDTH - OFFSET_BITS - INDEX_WIDTH;
  // A direct-mapped build still carries a 1-bit pointer. It stays at 0.
  localparam int PTR_WIDTH   = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [CTR_WIDTH-1:0]   CTR_MAX  = '1;
  localparam logic [CTR_WIDTH-1:0]   CTR_INIT = CTR_WIDTH'(2 ** (CTR_WIDTH - 1));
  localparam logic [PTR_WIDTH-1:0]   RR_LAST  = PTR_WIDTH'(WAYS - 1);
  localparam logic [INDEX_WIDTH-1:0] SET_LAST = INDEX_WIDTH'(SETS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] set_cnt_q, set_cnt_d;

  // Entry storage. Only valid and the pointer are ever cleared.
  logic [WAYS-1:0]       valid_q  [SETS];
  logic [TAG_WIDTH-1:0]  tag_q    [SETS][WAYS];
  logic [ADDR_WIDTH-1:0] target_q [SETS][WAYS];
  logic [CTR_WIDTH-1:0]  ctr_q    [SETS][WAYS];
  logic [PTR_WIDTH-1:0]  rr_q     [SETS];

  logic unused_low_pc_bits;
  assign unused_low_pc_bits = ^{lookup_pc_i[OFFSET_BITS-1:0], upd_pc_i[OFFSET_BITS-1:0]};

  assign busy_o = (state_q == FLUSH);

  // ---------------------------------------------------------------------------
  // Flush FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FLUSH;
      set_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      set_cnt_q <= set_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    set_cnt_d = set_cnt_q;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d   = FLUSH;
          set_cnt_d = '0;
        end
      end
      FLUSH: begin
        set_cnt_d = set_cnt_q + INDEX_WIDTH'(1);
        if (set_cnt_q == SET_LAST) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = FLUSH;
        set_cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Lookup. This is purely combinational on pre-update state. There is no
  // bypass from a same-cycle update. Tags are unique within a set, so OR-ing
  // over the matching ways is safe.
  // ---------------------------------------------------------------------------
  logic [INDEX_WIDTH-1:0] lk_idx;
  logic [TAG_WIDTH-1:0]   lk_tag;

  assign lk_idx = lookup_pc_i[OFFSET_BITS +: INDEX_WIDTH];
  assign lk_tag = lookup_pc_i[ADDR_WIDTH-1 -: TAG_WIDTH];

  always_comb begin
    hit_o        = 1'b0;
    pred_taken_o = 1'b0;
    target_o     = '0;
    if (state_q == IDLE) begin
      for (int w = 0; w < WAYS; w++) begin
        if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
          hit_o        = 1'b1;
          pred_taken_o = ctr_q[lk_idx][w][CTR_WIDTH-1];
          target_o     = target_q[lk_idx][w];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Update decode: hit way, victim way, and next counter / pointer values
  // ---------------------------------------------------------------------------
  logic [INDEX_WIDTH-1:0] upd_idx;
  logic [TAG_WIDTH-1:0]   upd_tag;
  logic                   upd_en;
  logic                   upd_hit;
  logic [PTR_WIDTH-1:0]   hit_way;
  logic                   any_invalid;
  logic [PTR_WIDTH-1:0]   victim;
  logic [PTR_WIDTH-1:0]   rr_next;
  logic [CTR_WIDTH-1:0]   ctr_cur;
  logic [CTR_WIDTH-1:0]   ctr_next;

  assign upd_idx = upd_pc_i[OFFSET_BITS +: INDEX_WIDTH];
  assign upd_tag = upd_pc_i[ADDR_WIDTH-1 -: TAG_WIDTH];
  // A flush request wins over a simultaneous update.
  assign upd_en  = (state_q == IDLE) && upd_valid_i && !flush_i && !rst;

  always_comb begin
    upd_hit     = 1'b0;
    hit_way     = '0;
    any_invalid = 1'b0;
    victim      = rr_q[upd_idx];
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[upd_idx][w] && (tag_q[upd_idx][w] == upd_tag)) begin
        upd_hit = 1'b1;
        hit_way = PTR_WIDTH'(w);
      end
    end
    // Scan downwards so that the lowest-numbered invalid way is the one kept.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[upd_idx][w]) begin
        any_invalid = 1'b1;
        victim      = PTR_WIDTH'(w);
      end
    end
  end

  // The pointer wraps explicitly, so a non-power-of-2 WAYS never reaches an
  // unused way number.
  assign rr_next = (rr_q[upd_idx] == RR_LAST) ? '0 : rr_q[upd_idx] + PTR_WIDTH'(1);

  assign ctr_cur = ctr_q[upd_idx][hit_way];

  always_comb begin
    ctr_next = ctr_cur;
    if (upd_taken_i) begin
      if (ctr_cur != CTR_MAX) ctr_next = ctr_cur + CTR_WIDTH'(1);
    end else begin
      if (ctr_cur != '0) ctr_next = ctr_cur - CTR_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Storage writes. The sweep clears one set per cycle. Updates apply only in
  // IDLE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (state_q == FLUSH) begin
      valid_q[set_cnt_q] <= '0;
      rr_q[set_cnt_q]    <= '0;
    end else if (upd_en) begin
      if (upd_hit) begin
        ctr_q[upd_idx][hit_way] <= ctr_next;
        if (upd_taken_i) begin
          target_q[upd_idx][hit_way] <= upd_target_i;
        end
      end else if (upd_taken_i) begin
        valid_q[upd_idx][victim]  <= 1'b1;
        tag_q[upd_idx][victim]    <= upd_tag;
        target_q[upd_idx][victim] <= upd_target_i;
        ctr_q[upd_idx][victim]    <= CTR_INIT;
        if (!any_invalid) begin
          rr_q[upd_idx] <= rr_next;
        end
      end
    end
  end

endmodule
